trp_cmd_seq: RTL
================

# trp_cmd_seq

Command sequencer directly upstream of the transposer. Accepts transpose descriptors over a valid/ready interface, queues them, programs the transposer configuration outputs, issues a one-cycle `init_pulse`, waits for `finish`, and returns one tagged status response per descriptor. It lets software or a DMA front end queue back-to-back jobs without polling.

## Interface
- `AW`, 16: address/count width; matches the transposer.
- `ADIM`, 6: nested address dimensions.
- `CQD`, 4: command queue depth, power of two, at least 2.
- `TOW`, 20: timeout counter width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_vld`/`cmd_rdy`  in/out  1/1  command handshake; `cmd_rdy` = queue not full.
- `cmd_tag`  in  4  job tag, echoed in the response.
- `cmd_mode`, `cmd_repack`  in  2, 1  transposer mode (01 = 8-bit, 10 = 32-bit) and repack enable.
- `cmd_rreq_num`, `cmd_wreq_num`, `cmd_raddr_base`, `cmd_waddr_base`, `cmd_packed`, `cmd_unpacked`  in  AW each  descriptor scalars.
- `cmd_raddr_size`, `cmd_raddr_stride`, `cmd_waddr_size`, `cmd_waddr_stride`  in  AW×[ADIM]  descriptor arrays.
- `timeout_cycles`  in  TOW  BUSY-cycle limit; 0 disables the timeout.
- `init_pulse`, `repack_en`, `mode`  out  1, 1, 2  to the transposer.
- `rreq_num`, `raddr_base`, `raddr_size[ADIM]`, `raddr_stride[ADIM]`, `wreq_num`, `waddr_base`, `waddr_size[ADIM]`, `waddr_stride[ADIM]`, `packed_dim_size`, `unpacked_dim_size`  out  AW  registered configuration.
- `finish`  in  1  transposer completion pulse.
- `rsp_vld`/`rsp_rdy`  out/in  1/1  response handshake.
- `rsp_tag`, `rsp_status`  out  4, 2  tag; status 00 = OK, 01 = BADCFG, 10 = TIMEOUT.
- `busy`  out  1  high in any state other than IDLE, or while the queue is not empty.

## Operation
- Reset: every output is 0 except `cmd_rdy`, which is 1. The FSM is in IDLE and the queue is empty.
- The queue accepts a command when `cmd_vld & cmd_rdy`. When full, `cmd_rdy` = 0 and `cmd_vld` is ignored. The queue does not accept a command in the cycle reset deasserts.
- FSM states: IDLE, LOAD, START, BUSY, RESP.
- **IDLE:** if the queue is not empty, pop the head and go to LOAD.
- **LOAD:** register all configuration outputs from the popped descriptor. Validate it:
  - BADCFG if `cmd_repack` is set and `cmd_mode` is not 01 or 10.
  - BADCFG if `cmd_rreq_num` = 0 or `cmd_wreq_num` = 0.
  - BADCFG goes to RESP with status 01. No `init_pulse` is issued.
  - Otherwise go to START.
- **START:** drive `init_pulse` = 1 for exactly one cycle, clear the timeout counter, go to BUSY.
- **BUSY:** wait for `finish` = 1, then go to RESP with status 00.
  - The timeout counter increments each BUSY cycle.
  - If `timeout_cycles` ≠ 0 and the counter equals `timeout_cycles`, go to RESP with status 10.
  - `finish` and the timeout in the same cycle: `finish` wins (status OK).
- **RESP:** hold `rsp_vld` = 1 with `rsp_tag` and `rsp_status` stable until `rsp_rdy`. On the handshake go to IDLE.
- Configuration outputs hold their values from LOAD until the next LOAD, so they are stable throughout BUSY.
- `finish` seen outside BUSY is ignored. A stale late `finish` after a timeout is discarded, because the next `init_pulse` restarts the transposer.
- Reset during any state aborts immediately. No response is generated for the in-flight or queued jobs.
- Queue push and pop in the same cycle are both legal. Occupancy is unchanged and a full queue stays full.

## Timing
- Command accepted at cycle t, queue empty, FSM in IDLE:
  - pop at t+1;
  - LOAD at t+2, configuration outputs valid from t+3;
  - `init_pulse` high during t+3 (START);
  - BUSY from t+4.
- `finish` at cycle f: `rsp_vld` is high from f+1.
- `rsp_vld & rsp_rdy` at cycle r: IDLE at r+1; the next pop is at r+1 if the queue is not empty.
- Minimum spacing between consecutive `init_pulse` edges is 5 cycles plus the job duration.
- A timeout fires on the BUSY cycle where the counter, which starts at 0 on BUSY entry, equals `timeout_cycles`. `rsp_vld` is high the following cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `TRP_CMD_TIMEOUT_EN`:
  - **Defined:** the timeout counter and status 10 exist as described.
  - **Undefined:** the counter is removed, `timeout_cycles` is ignored, BUSY exits only on `finish`, and status 10 is never produced.

## Structure
- Package `trp_pkg` holds:
  - `mode_t` (BIT8_MODE = 01, BIT32_MODE = 10);
  - `rsp_status_t` (OK, BADCFG, TIMEOUT);
  - `seq_state_t`;
  - the packed descriptor struct `trp_cmd_t`, which is the queue payload.
- The command queue is one instance of the existing `fwft_fifo`, with `FD` = CQD and `DW` = $bits(trp_cmd_t).
- The FSM, output registers, validation and timeout logic live in `trp_cmd_seq`.

## Test plan
- **Single job:** push 1 valid cmd (tag 3, mode 01, repack 1, rreq_num = wreq_num = 8). Expect one `init_pulse` 3 cycles after acceptance, with the configuration equal to the descriptor. Drive `finish` 20 cycles later; expect the response tag 3, status 00, the next cycle.
- **Back-to-back queue:** push 4 cmds, tags 0–3, without gaps. Expect `cmd_rdy` low while full, 4 `init_pulse`s in order, and responses tagged 0–3 in order.
- **Bad config:** a cmd with mode 11 and repack 1. Expect no `init_pulse` and a response with status 01. Repeat with `wreq_num` = 0: same result.
- **Timeout** (`TRP_CMD_TIMEOUT_EN` defined, `timeout_cycles` = 10, no `finish`): expect status 10 one cycle after the 10th BUSY cycle. Then drive a stale `finish`; the FSM state is unaffected.
- **Response backpressure:** hold `rsp_rdy` low for 7 cycles. Expect `rsp_vld`, tag and status stable throughout and no new `init_pulse` until the handshake.
- **Mid-job reset:** assert `reset` in BUSY with 2 jobs queued. Expect all outputs at their reset values, `cmd_rdy` = 1, the queue empty, and no responses afterwards.

Source files
------------

// File: rtl/trp_pkg.sv
// Shared types for the transposer command sequencer: modes, response status,
// FSM states and the queued descriptor layout.
package trp_pkg;

  localparam int TRP_AW   = 16;
  localparam int TRP_ADIM = 6;

  typedef enum logic [1:0] {
    BIT8_MODE  = 2'b01,
    BIT32_MODE = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    BADCFG  = 2'b01,
    TIMEOUT = 2'b10
  } rsp_status_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BUSY,
    RESP
  } seq_state_t;

  // mode is kept as raw bits: illegal encodings must survive the queue to be rejected
  typedef struct packed {
    logic [3:0]                           tag;
    logic [1:0]                           mode;
    logic                                 repack;
    logic [TRP_AW-1:0]                    rreq_num;
    logic [TRP_AW-1:0]                    wreq_num;
    logic [TRP_AW-1:0]                    raddr_base;
    logic [TRP_AW-1:0]                    waddr_base;
    logic [TRP_AW-1:0]                    packed_dim;
    logic [TRP_AW-1:0]                    unpacked_dim;
    logic [TRP_ADIM-1:0][TRP_AW-1:0]      raddr_size;
    logic [TRP_ADIM-1:0][TRP_AW-1:0]      raddr_stride;
    logic [TRP_ADIM-1:0][TRP_AW-1:0]      waddr_size;
    logic [TRP_ADIM-1:0][TRP_AW-1:0]      waddr_stride;
  } trp_cmd_t;

  function automatic logic cfg_bad(input trp_cmd_t c);
    return (c.repack && (c.mode != 2'(BIT8_MODE)) && (c.mode != 2'(BIT32_MODE)))
        || (c.rreq_num == '0) || (c.wreq_num == '0);
  endfunction

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: dout shows the head entry whenever empty is low.
// FD must be a power of two.
module fwft_fifo #(
  parameter int FD = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty
);
  localparam int PW = $clog2(FD);

  logic [DW-1:0] mem [FD];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (cnt == (PW+1)'(FD));
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/trp_cmd_seq.sv
// Transposer command sequencer: queues descriptors, programs the transposer, pulses
// init, waits for finish and returns a tagged status. TRP_CMD_TIMEOUT_EN adds the BUSY timeout.
module trp_cmd_seq
  import trp_pkg::*;
#(
  parameter int AW   = TRP_AW,
  parameter int ADIM = TRP_ADIM,
  parameter int CQD  = 4,
  parameter int TOW  = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic [3:0]      cmd_tag,
  input  logic [1:0]      cmd_mode,
  input  logic            cmd_repack,
  input  logic [AW-1:0]   cmd_rreq_num,
  input  logic [AW-1:0]   cmd_wreq_num,
  input  logic [AW-1:0]   cmd_raddr_base,
  input  logic [AW-1:0]   cmd_waddr_base,
  input  logic [AW-1:0]   cmd_packed,
  input  logic [AW-1:0]   cmd_unpacked,
  input  logic [AW-1:0]   cmd_raddr_size   [ADIM],
  input  logic [AW-1:0]   cmd_raddr_stride [ADIM],
  input  logic [AW-1:0]   cmd_waddr_size   [ADIM],
  input  logic [AW-1:0]   cmd_waddr_stride [ADIM],
  input  logic [TOW-1:0]  timeout_cycles,
  output logic            init_pulse,
  output logic            repack_en,
  output logic [1:0]      mode,
  output logic [AW-1:0]   rreq_num,
  output logic [AW-1:0]   raddr_base,
  output logic [AW-1:0]   raddr_size   [ADIM],
  output logic [AW-1:0]   raddr_stride [ADIM],
  output logic [AW-1:0]   wreq_num,
  output logic [AW-1:0]   waddr_base,
  output logic [AW-1:0]   waddr_size   [ADIM],
  output logic [AW-1:0]   waddr_stride [ADIM],
  output logic [AW-1:0]   packed_dim_size,
  output logic [AW-1:0]   unpacked_dim_size,
  input  logic            finish,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [3:0]      rsp_tag,
  output logic [1:0]      rsp_status,
  output logic            busy
);

  seq_state_t state;
  trp_cmd_t   desc;
  trp_cmd_t   head;
  trp_cmd_t   cur;
  logic       q_full;
  logic       q_empty;
  logic       q_pop;
  logic       to_hit;

  always_comb begin
    desc              = '0;
    desc.tag          = cmd_tag;
    desc.mode         = cmd_mode;
    desc.repack       = cmd_repack;
    desc.rreq_num     = cmd_rreq_num;
    desc.wreq_num     = cmd_wreq_num;
    desc.raddr_base   = cmd_raddr_base;
    desc.waddr_base   = cmd_waddr_base;
    desc.packed_dim   = cmd_packed;
    desc.unpacked_dim = cmd_unpacked;
    for (int i = 0; i < ADIM; i++) begin
      desc.raddr_size[i]   = cmd_raddr_size[i];
      desc.raddr_stride[i] = cmd_raddr_stride[i];
      desc.waddr_size[i]   = cmd_waddr_size[i];
      desc.waddr_stride[i] = cmd_waddr_stride[i];
    end
  end

  assign cmd_rdy = ~q_full;
  assign q_pop   = (state == IDLE) & ~q_empty;
  assign busy    = (state != IDLE) | ~q_empty;

  fwft_fifo #(
    .FD (CQD),
    .DW ($bits(trp_cmd_t))
  ) u_cmd_q (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_vld & ~q_full),
    .din   (desc),
    .full  (q_full),
    .pop   (q_pop),
    .dout  (head),
    .empty (q_empty)
  );

`ifdef TRP_CMD_TIMEOUT_EN
  // to_cnt counts completed BUSY cycles, so the limit hits on BUSY cycle number timeout_cycles
  logic [TOW-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                to_cnt <= '0;
    else if (state == START)  to_cnt <= '0;
    else if (state == BUSY)   to_cnt <= to_cnt + TOW'(1);
  end

  assign to_hit = (timeout_cycles != '0) && ((to_cnt + TOW'(1)) == timeout_cycles);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cur               <= '0;
      init_pulse        <= 1'b0;
      repack_en         <= 1'b0;
      mode              <= '0;
      rreq_num          <= '0;
      wreq_num          <= '0;
      raddr_base        <= '0;
      waddr_base        <= '0;
      packed_dim_size   <= '0;
      unpacked_dim_size <= '0;
      for (int i = 0; i < ADIM; i++) begin
        raddr_size[i]   <= '0;
        raddr_stride[i] <= '0;
        waddr_size[i]   <= '0;
        waddr_stride[i] <= '0;
      end
      rsp_vld           <= 1'b0;
      rsp_tag           <= '0;
      rsp_status        <= '0;
    end else begin
      init_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            cur   <= head;
            state <= LOAD;
          end
        end
        LOAD: begin
          repack_en         <= cur.repack;
          mode              <= cur.mode;
          rreq_num          <= cur.rreq_num;
          wreq_num          <= cur.wreq_num;
          raddr_base        <= cur.raddr_base;
          waddr_base        <= cur.waddr_base;
          packed_dim_size   <= cur.packed_dim;
          unpacked_dim_size <= cur.unpacked_dim;
          for (int i = 0; i < ADIM; i++) begin
            raddr_size[i]   <= cur.raddr_size[i];
            raddr_stride[i] <= cur.raddr_stride[i];
            waddr_size[i]   <= cur.waddr_size[i];
            waddr_stride[i] <= cur.waddr_stride[i];
          end
          rsp_tag <= cur.tag;
          if (cfg_bad(cur)) begin
            rsp_status <= BADCFG;
            rsp_vld    <= 1'b1;
            state      <= RESP;
          end else begin
            init_pulse <= 1'b1;
            state      <= START;
          end
        end
        START: state <= BUSY;
        BUSY: begin
          // finish beats a timeout landing in the same cycle
          if (finish) begin
            rsp_status <= OK;
            rsp_vld    <= 1'b1;
            state      <= RESP;
          end else if (to_hit) begin
            rsp_status <= TIMEOUT;
            rsp_vld    <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
